// File: rtl/audio_frame_drain.sv
// Drains NUM_CHANNELS lockstep FWFT FIFOs into one multi-channel frame per pop, handing frames
// downstream with valid/ready. Optional golden-reference checking under AUDIO_FRAME_DRAIN_CMP_EN.
module audio_frame_drain #(
  parameter int DATA_SIZE    = 32,
  parameter int NUM_CHANNELS = 2,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic [COUNT_WIDTH-1:0]            frame_target,
  input  logic [NUM_CHANNELS-1:0]           ch_empty,
  input  logic [NUM_CHANNELS*DATA_SIZE-1:0] ch_dout,
  output logic [NUM_CHANNELS-1:0]           ch_rd_en,
  output logic                              frame_valid,
  input  logic                              frame_ready,
  output logic [NUM_CHANNELS*DATA_SIZE-1:0] frame_data,
  output logic [COUNT_WIDTH-1:0]            frame_index,
  output logic                              busy,
  output logic                              done
`ifdef AUDIO_FRAME_DRAIN_CMP_EN
  ,
  input  logic                              exp_empty,
  input  logic [NUM_CHANNELS*DATA_SIZE-1:0] exp_dout,
  output logic                              exp_rd_en,
  output logic [NUM_CHANNELS-1:0]           err_mask,
  output logic [31:0]                       error_count
`endif
);

  typedef enum logic [1:0] {IDLE, COLLECT, OUTPUT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] target_q;
  logic [COUNT_WIDTH-1:0] idx_next;
  logic                   pop;
  logic                   take_start;
  logic                   src_ready;

`ifdef AUDIO_FRAME_DRAIN_CMP_EN
  assign src_ready = ~|ch_empty & ~exp_empty;
`else
  assign src_ready = ~|ch_empty;
`endif

  assign idx_next   = frame_index + 1'b1;
  assign take_start = start & ((state_q == IDLE) | (state_q == DONE));

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) state_d = (frame_target == '0) ? DONE : COLLECT;
      end
      COLLECT: begin
        // all channels pop together or not at all, so frames never tear
        if (src_ready) begin
          pop     = 1'b1;
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        if (frame_ready) state_d = (idx_next == target_q) ? DONE : COLLECT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      target_q    <= '0;
      frame_index <= '0;
      frame_data  <= '0;
    end else begin
      state_q <= state_d;
      if (take_start) begin
        target_q    <= frame_target;
        frame_index <= '0;
      end
      if (pop) frame_data <= ch_dout;
      if (state_q == OUTPUT && frame_ready) frame_index <= idx_next;
    end
  end

  assign ch_rd_en    = {NUM_CHANNELS{pop}};
  assign frame_valid = (state_q == OUTPUT);
  assign busy        = (state_q == COLLECT) | (state_q == OUTPUT);
  assign done        = (state_q == DONE);

`ifdef AUDIO_FRAME_DRAIN_CMP_EN
  logic [NUM_CHANNELS-1:0] mismatch;
  logic [31:0]             mis_cnt;
  logic [32:0]             cnt_sum;

  always_comb begin
    mismatch = '0;
    mis_cnt  = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      mismatch[k] = ch_dout[k*DATA_SIZE +: DATA_SIZE] != exp_dout[k*DATA_SIZE +: DATA_SIZE];
      mis_cnt     = mis_cnt + 32'(mismatch[k]);
    end
  end

  assign cnt_sum   = {1'b0, error_count} + {1'b0, mis_cnt};
  assign exp_rd_en = pop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_mask    <= '0;
      error_count <= '0;
    end else if (take_start) begin
      err_mask    <= '0;
      error_count <= '0;
    end else if (pop) begin
      err_mask    <= mismatch;
      error_count <= cnt_sum[32] ? '1 : cnt_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_audio_frame_drain.sv
// Bench for audio_frame_drain: table of runs, hand-written corner sequences and random runs,
// all checked cycle by cycle against a queue-based frame model.
module tb_audio_frame_drain;
  localparam int DW = 32, NCH = 2, CW = 16;

  logic            clock = 1'b0;
  logic            reset, start, frame_ready;
  logic [CW-1:0]   frame_target;
  logic [NCH-1:0]  ch_empty, ch_rd_en;
  logic [NCH*DW-1:0] ch_dout, frame_data;
  logic            frame_valid, busy, done;
  logic [CW-1:0]   frame_index;
`ifdef AUDIO_FRAME_DRAIN_CMP_EN
  logic            exp_empty;
  logic [NCH*DW-1:0] exp_dout;
  logic            exp_rd_en;
  logic [NCH-1:0]  err_mask;
  logic [31:0]     error_count;
`endif

  audio_frame_drain #(.DATA_SIZE(DW), .NUM_CHANNELS(NCH), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .start(start), .frame_target(frame_target),
    .ch_empty(ch_empty), .ch_dout(ch_dout), .ch_rd_en(ch_rd_en),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_data(frame_data),
    .frame_index(frame_index), .busy(busy), .done(done)
`ifdef AUDIO_FRAME_DRAIN_CMP_EN
    , .exp_empty(exp_empty), .exp_dout(exp_dout), .exp_rd_en(exp_rd_en),
    .err_mask(err_mask), .error_count(error_count)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0, failures = 0;

  // source FIFOs and abstract run model
  logic [DW-1:0] q0[$], q1[$];
  logic [1:0]    hold;
  logic [63:0]   inj;
  bit            auto_fill;
  bit            m_started, m_active, m_pending;
  logic [63:0]   m_pend_data;
  int            m_target, m_accepted, dut_pops;
  logic [1:0]    m_err_mask;
  int            m_err_cnt;

  typedef struct {
    int target;
    int right_empty_cycles;
    int ready_low_cycles;
    int exp_pops;
  } run_t;
  run_t runs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    if (auto_fill) begin
      while (q0.size() < 3) q0.push_back($urandom);
      while (q1.size() < 3) q1.push_back($urandom);
    end
    ch_empty[0] = (q0.size() == 0) || hold[0];
    ch_empty[1] = (q1.size() == 0) || hold[1];
    ch_dout[31:0]  = (q0.size() != 0) ? q0[0] : 32'h0;
    ch_dout[63:32] = (q1.size() != 0) ? q1[0] : 32'h0;
`ifdef AUDIO_FRAME_DRAIN_CMP_EN
    exp_empty = 1'b0;
    exp_dout  = ch_dout ^ inj;
`endif
  endtask

  function automatic bit exp_pop();
    return m_active && !m_pending && !ch_empty[0] && !ch_empty[1];
  endfunction

  task automatic cycle_check();
    check("rd_en", ch_rd_en, {2{exp_pop()}});
    check("frame_valid", frame_valid, m_pending);
    if (m_pending) check("frame_data", frame_data, m_pend_data);
    check("frame_index", frame_index, 64'(m_accepted));
    check("busy", busy, m_active);
    check("done", done, m_started && !m_active);
`ifdef AUDIO_FRAME_DRAIN_CMP_EN
    check("exp_rd_en", exp_rd_en, exp_pop());
    check("err_mask", err_mask, m_err_mask);
    check("error_count", error_count, 64'(m_err_cnt));
`endif
  endtask

  // called at posedge+1 with inputs set; returns at the next posedge+1 with the model advanced
  task automatic tick();
    bit e_st, e_rd, e_acc;
    int tgt;
    logic [63:0] d_s, x_s;
    refresh();
    #2;
    cycle_check();
    e_st  = start && !m_active;
    e_rd  = exp_pop();
    e_acc = m_pending && frame_ready;
    tgt   = int'(frame_target);
    d_s   = ch_dout;
    x_s   = d_s ^ inj;
    if (ch_rd_en[0]) dut_pops++;
    @(posedge clock);
    #1;
    start = 1'b0;
    if (e_st) begin
      m_started = 1; m_target = tgt; m_accepted = 0; m_active = (tgt != 0);
      m_pending = 0; m_err_mask = 0; m_err_cnt = 0;
    end else begin
      if (e_acc) begin
        m_accepted++;
        m_pending = 0;
        if (m_accepted == m_target) m_active = 0;
      end
      if (e_rd) begin
        m_pending   = 1;
        m_pend_data = d_s;
        void'(q0.pop_front());
        void'(q1.pop_front());
        m_err_mask[0] = d_s[31:0]  != x_s[31:0];
        m_err_mask[1] = d_s[63:32] != x_s[63:32];
        m_err_cnt += int'(m_err_mask[0]) + int'(m_err_mask[1]);
      end
    end
    refresh();
  endtask

  task automatic model_reset();
    m_started = 0; m_active = 0; m_pending = 0; m_pend_data = '0;
    m_target = 0; m_accepted = 0; m_err_mask = 0; m_err_cnt = 0;
  endtask

  task automatic finish_run(input int budget);
    int n = 0;
    while (m_active && n < budget) begin
      frame_ready = 1'b1;
      tick();
      n++;
    end
    if (m_active) begin
      checks++; failures++;
      $display("FAIL run_timeout actual=%0d required_frames=%0d", m_accepted, m_target);
    end
    tick();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; frame_ready = 1'b1; frame_target = '0;
    hold = 2'b00; inj = '0; auto_fill = 1; dut_pops = 0;
    model_reset();
    refresh();
    repeat (2) @(posedge clock);
    #1;
    check("rst_valid", frame_valid, 0);
    check("rst_data", frame_data, 0);
    check("rst_index", frame_index, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", ch_rd_en, 0);
    reset = 1'b0;
    tick();

    runs[0] = '{3, 0, 0, 3};
    runs[1] = '{2, 5, 0, 2};
    runs[2] = '{2, 0, 4, 2};
    runs[3] = '{0, 0, 0, 0};
    runs[4] = '{5, 2, 3, 5};
    for (int r = 0; r < 5; r++) begin
      int n, low_left;
      dut_pops = 0;
      low_left = runs[r].ready_low_cycles;
      hold[1] = (runs[r].right_empty_cycles > 0);
      frame_target = CW'(runs[r].target);
      start = 1'b1;
      tick();
      n = 0;
      while (m_active && n < 200) begin
        hold[1] = (n < runs[r].right_empty_cycles);
        if (m_pending && low_left > 0) begin
          frame_ready = 1'b0;
          low_left--;
        end else frame_ready = 1'b1;
        tick();
        n++;
      end
      hold = 2'b00;
      finish_run(50);
      check($sformatf("run%0d_pops", r), dut_pops, runs[r].exp_pops);
      check($sformatf("run%0d_index", r), frame_index, runs[r].target);
      check($sformatf("run%0d_done", r), done, 1);
    end

    // start while busy must be ignored
    frame_target = 16'd4; start = 1'b1;
    tick(); tick(); tick();
    frame_target = 16'd9; start = 1'b1;
    tick();
    finish_run(100);
    check("busy_start_index", frame_index, 4);

    // reset with a frame pending in OUTPUT, then a fresh run
    frame_target = 16'd3; frame_ready = 1'b0; start = 1'b1;
    tick();
    for (int n = 0; n < 10 && !m_pending; n++) tick();
    tick();
    #1 reset = 1'b1;
    #1;
    check("mid_rst_valid", frame_valid, 0);
    check("mid_rst_data", frame_data, 0);
    check("mid_rst_index", frame_index, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_rd_en", ch_rd_en, 0);
    model_reset();
    @(posedge clock);
    #1 reset = 1'b0;
    frame_ready = 1'b1;
    tick();
    frame_target = 16'd2; start = 1'b1;
    tick();
    finish_run(50);
    check("post_rst_index", frame_index, 2);

`ifdef AUDIO_FRAME_DRAIN_CMP_EN
    // channel 1 of frame 2 disagrees with the golden stream in bit 0
    auto_fill = 0;
    q0.delete(); q1.delete();
    q0.push_back(32'hA0); q0.push_back(32'hA1);
    q1.push_back(32'hB0); q1.push_back(32'h0000_1234);
    frame_target = 16'd2; start = 1'b1;
    tick();
    for (int n = 0; n < 20 && m_active; n++) begin
      inj = (m_accepted == 1) ? 64'h0000_0001_0000_0000 : 64'h0;
      tick();
    end
    inj = '0;
    tick();
    check("cmp_err_mask", err_mask, 2'b10);
    check("cmp_error_count", error_count, 1);
    auto_fill = 1;
`endif

    // random runs with random starvation, back-pressure and stray starts
    for (int r = 0; r < 20; r++) begin
      int n = 0;
      frame_target = CW'($urandom_range(8, 1));
      start = 1'b1;
      tick();
      while (m_active && n < 400) begin
        hold = 2'($urandom_range(3, 0) == 0 ? $urandom_range(3, 1) : 0);
        frame_ready = ($urandom_range(1, 0) == 1);
        if ($urandom_range(15, 0) == 0) begin
          start = 1'b1;
          frame_target = CW'($urandom);
        end
        tick();
        n++;
      end
      hold = 2'b00;
      finish_run(50);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
